// File: rtl/johnson_chaser_gen.sv
// Pattern chaser (Johnson / ring / bounce / hold) stepped by a synchronous prescaler tick.
// Latency: pattern, tick and wrap update on the same edge; mode reload takes one edge; ext_step edge to step is 3 edges.
// Backpressure: none; enable=0 freezes the prescaler and pattern, and a mode change still reloads.
// Optional feature macro: JOHNSON_CHASER_EXT_STEP_EN adds the ext_step input (synchronised external step request).

module johnson_chaser_gen #(
    parameter int WIDTH    = 5,   // pattern width, 2..8
    parameter int DIV_BITS = 13   // prescaler width, 1..16
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active-low
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [3:0]       div_sel,
`ifdef JOHNSON_CHASER_EXT_STEP_EN
    input  logic             ext_step,   // asynchronous source
`endif
    output logic [WIDTH-1:0] pattern,
    output logic             tick,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_JOHNSON = 2'b00,
        MODE_RING    = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    // Largest usable prescaler bit index for the tick compare.
    localparam logic [3:0] K_MAX = 4'(DIV_BITS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mode_e                r_mode_q;
    logic [DIV_BITS-1:0]  r_presc;
    logic [WIDTH-1:0]     r_pattern;
    logic                 r_tick;
    logic                 r_wrap;
    logic                 r_bounce_up;   // 1 = one-hot bit travelling toward MSB

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic                 w_mode_chg;
    logic [3:0]           w_k;
    logic [DIV_BITS-1:0]  w_mask;
    logic                 w_presc_hit;
    logic                 w_tick_cond;
    logic [WIDTH-1:0]     w_reload_pat;
    logic [WIDTH-1:0]     w_start_q;
    logic [WIDTH-1:0]     w_step_pat;
    logic                 w_step_up;
    logic                 w_wrap_hit;
    logic                 w_bounce_move_up;
    logic [WIDTH-1:0]     w_bounce_shift;

    // Start value a mode sequence returns to; hold keeps whatever is current.
    function automatic logic [WIDTH-1:0] start_val(input logic [1:0] m,
                                                   input logic [WIDTH-1:0] cur);
        logic [WIDTH-1:0] v;
        v = cur;
        case (m)
            MODE_JOHNSON: v = '0;
            MODE_RING:    v = WIDTH'(1);
            MODE_BOUNCE:  v = WIDTH'(1);
            default:      v = cur;
        endcase
        return v;
    endfunction

    assign w_mode_chg   = (mode != r_mode_q);
    assign w_reload_pat = start_val(mode, r_pattern);
    assign w_start_q    = start_val(r_mode_q, r_pattern);

    // Clamp the divide selector to the prescaler width and build the low-bits mask.
    always_comb begin
        w_mask = '0;
        w_k    = (div_sel > K_MAX) ? K_MAX : div_sel;
        for (int i = 0; i < DIV_BITS; i++) begin
            w_mask[i] = (4'(i) <= w_k);
        end
    end

    // Prescaler tick fires when the selected low bits are all ones.
    assign w_presc_hit = ((r_presc & w_mask) == w_mask);

`ifdef JOHNSON_CHASER_EXT_STEP_EN
    logic r_ext_meta;
    logic r_ext_sync;
    logic r_ext_last;
    logic w_ext_edge;

    // Two-flop synchroniser plus one delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ext_meta <= 1'b0;
            r_ext_sync <= 1'b0;
            r_ext_last <= 1'b0;
        end else begin
            r_ext_meta <= ext_step;
            r_ext_sync <= r_ext_meta;
            r_ext_last <= r_ext_sync;
        end
    end

    assign w_ext_edge  = r_ext_sync & ~r_ext_last;
    // A coincident external edge and prescaler hit still produce only one step.
    assign w_tick_cond = enable & (w_presc_hit | w_ext_edge);
`else
    assign w_tick_cond = enable & w_presc_hit;
`endif

    // Bounce direction: forced at the ends, otherwise follows the flag.
    always_comb begin
        w_bounce_move_up = r_bounce_up;
        if (r_pattern[0]) begin
            w_bounce_move_up = 1'b1;
        end else if (r_pattern[WIDTH-1]) begin
            w_bounce_move_up = 1'b0;
        end
        w_bounce_shift = w_bounce_move_up ? (r_pattern << 1) : (r_pattern >> 1);
    end

    // Next pattern and bounce flag for a tick in the current mode.
    always_comb begin
        w_step_pat = r_pattern;
        w_step_up  = r_bounce_up;
        case (r_mode_q)
            MODE_JOHNSON: begin
                if (dir) begin
                    w_step_pat = {~r_pattern[0], r_pattern[WIDTH-1:1]};
                end else begin
                    w_step_pat = {r_pattern[WIDTH-2:0], ~r_pattern[WIDTH-1]};
                end
            end
            MODE_RING: begin
                if (r_pattern == '0) begin
                    // An empty ring would rotate forever as zero; seed it.
                    w_step_pat = WIDTH'(1);
                end else if (dir) begin
                    w_step_pat = {r_pattern[0], r_pattern[WIDTH-1:1]};
                end else begin
                    w_step_pat = {r_pattern[WIDTH-2:0], r_pattern[WIDTH-1]};
                end
            end
            MODE_BOUNCE: begin
                if (!$onehot(r_pattern)) begin
                    // Corrupt or leftover pattern: restart the bounce from bit 0.
                    w_step_pat = WIDTH'(1);
                    w_step_up  = 1'b1;
                end else begin
                    w_step_pat = w_bounce_shift;
                    if (w_bounce_shift[WIDTH-1]) begin
                        w_step_up = 1'b0;
                    end else if (w_bounce_shift[0]) begin
                        w_step_up = 1'b1;
                    end else begin
                        w_step_up = w_bounce_move_up;
                    end
                end
            end
            default: begin
                w_step_pat = r_pattern;
                w_step_up  = r_bounce_up;
            end
        endcase
    end

    // Wrap marks arrival at the start value from somewhere else; hold never wraps.
    assign w_wrap_hit = (r_mode_q != MODE_HOLD) &&
                        (w_step_pat == w_start_q) &&
                        (r_pattern != w_start_q);

    // Mode register: follows the mode input one edge after it changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode_q <= MODE_JOHNSON;
        end else if (w_mode_chg) begin
            r_mode_q <= mode_e'(mode);
        end
    end

    // Prescaler: cleared on mode change, otherwise counts while enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (w_mode_chg) begin
            r_presc <= '0;
        end else if (enable) begin
            r_presc <= r_presc + DIV_BITS'(1);
        end
    end

    // Pattern and bounce flag: reload on mode change, step on tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pattern   <= '0;
            r_bounce_up <= 1'b1;
        end else if (w_mode_chg) begin
            r_pattern   <= w_reload_pat;
            r_bounce_up <= 1'b1;
        end else if (w_tick_cond) begin
            r_pattern   <= w_step_pat;
            r_bounce_up <= w_step_up;
        end
    end

    // Tick and wrap pulses: registered alongside the pattern, suppressed on reload edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (w_mode_chg) begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_tick <= w_tick_cond;
            r_wrap <= w_tick_cond & w_wrap_hit;
        end
    end

    assign pattern = r_pattern;
    assign tick    = r_tick;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_johnson_chaser_gen.sv
// Directed plus randomized bench for johnson_chaser_gen against an arithmetic reference model.
// Outputs are sampled 1 time unit after each rising edge; inputs change there too.
// Builds with or without JOHNSON_CHASER_EXT_STEP_EN.

module tb_johnson_chaser_gen;

    localparam int W  = 5;
    localparam int DB = 13;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [1:0]   mode;
    logic         dir;
    logic [3:0]   div_sel;
    logic         ext_step;
    logic [W-1:0] pattern;
    logic         tick;
    logic         wrap;

    always #5 clk = ~clk;

    johnson_chaser_gen #(.WIDTH(W), .DIV_BITS(DB)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .mode    (mode),
        .dir     (dir),
        .div_sel (div_sel),
`ifdef JOHNSON_CHASER_EXT_STEP_EN
        .ext_step(ext_step),
`endif
        .pattern (pattern),
        .tick    (tick),
        .wrap    (wrap)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (positions / arithmetic) ----------------
    int m_presc, m_pat, m_mode;
    bit m_up, m_tick, m_wrap;
    bit h1, h2, h3;   // ext_step as sampled 1, 2, 3 edges ago

    function automatic int start_of(input int md, input int cur);
        case (md)
            0:       return 0;
            1:       return 1;
            2:       return 1;
            default: return cur;
        endcase
    endfunction

    function automatic int popc(input int v);
        int c = 0;
        for (int i = 0; i < W; i++) c += (v >> i) & 1;
        return c;
    endfunction

    function automatic int bitpos(input int v);
        for (int i = 0; i < W; i++) if (((v >> i) & 1) == 1) return i;
        return 0;
    endfunction

    task automatic m_reset();
        m_presc = 0; m_pat = 0; m_mode = 0; m_up = 1'b1;
        m_tick = 1'b0; m_wrap = 1'b0;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    endtask

    task automatic model_step();
        int  full, k, per, np, st, pos;
        bit  forced, t, mu;
        full = 1 << W;
`ifdef JOHNSON_CHASER_EXT_STEP_EN
        forced = h2 && !h3;
`else
        forced = 1'b0;
`endif
        h3 = h2; h2 = h1; h1 = ext_step;
        if (int'(mode) != m_mode) begin
            m_mode  = int'(mode);
            m_presc = 0;
            m_pat   = start_of(m_mode, m_pat);
            m_up    = 1'b1;
            m_tick  = 1'b0;
            m_wrap  = 1'b0;
        end else begin
            k   = (int'(div_sel) > DB - 1) ? DB - 1 : int'(div_sel);
            per = 1 << (k + 1);
            t   = enable && (((m_presc % per) == per - 1) || forced);
            if (enable) m_presc = (m_presc + 1) % (1 << DB);
            m_tick = t;
            m_wrap = 1'b0;
            if (t) begin
                np = m_pat;
                case (m_mode)
                    0: np = dir ? (m_pat / 2 + ((m_pat % 2 == 1) ? 0 : full / 2))
                                : ((m_pat * 2) % full + ((m_pat >= full / 2) ? 0 : 1));
                    1: if (m_pat == 0) np = 1;
                       else np = dir ? (m_pat / 2 + (m_pat % 2) * (full / 2))
                                     : ((m_pat * 2) % full + ((m_pat >= full / 2) ? 1 : 0));
                    2: if (popc(m_pat) != 1) begin
                           np = 1; m_up = 1'b1;
                       end else begin
                           pos = bitpos(m_pat);
                           mu  = (pos == 0) ? 1'b1 : (pos == W - 1) ? 1'b0 : m_up;
                           pos = mu ? pos + 1 : pos - 1;
                           m_up = (pos == W - 1) ? 1'b0 : (pos == 0) ? 1'b1 : mu;
                           np  = 1 << pos;
                       end
                    default: np = m_pat;
                endcase
                st     = start_of(m_mode, m_pat);
                m_wrap = (m_mode != 3) && (np == st) && (m_pat != st);
                m_pat  = np;
            end
        end
    endtask

    // One clock: predict, wait for the edge, compare.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("pattern", 32'(pattern), 32'(m_pat));
        chk("tick",    32'(tick),    32'(m_tick));
        chk("wrap",    32'(wrap),    32'(m_wrap));
    endtask

    int jtab[11] = '{0, 1, 3, 7, 15, 31, 30, 28, 24, 16, 0};
    int rtab[5]  = '{16, 8, 4, 2, 1};
    int btab[8]  = '{2, 4, 8, 16, 8, 4, 2, 1};
    int etab[4]  = '{1, 3, 7, 15};

    initial begin
        reset = 1'b1; enable = 1'b1; mode = 2'b00; dir = 1'b0;
        div_sel = 4'd0; ext_step = 1'b0;
        m_reset();
        #1 reset = 1'b0;
        #1;
        chk("reset_pattern", 32'(pattern), 32'd0);
        chk("reset_tick",    32'(tick),    32'd0);
        chk("reset_wrap",    32'(wrap),    32'd0);
        #1 reset = 1'b1;

        // Johnson, div_sel=0: a step every 2 cycles, wrap on the 10th tick.
        for (int n = 1; n <= 10; n++) begin
            cyc(); cyc();
            chk("john_seq",  32'(pattern), 32'(jtab[n]));
            chk("john_tick", 32'(tick),    32'd1);
            chk("john_wrap", 32'(wrap),    32'(n == 10));
        end

        // Ring, dir=1, div_sel=2: reload to 1, ticks every 8 cycles, wrap every 5.
        mode = 2'b01; dir = 1'b1; div_sel = 4'd2;
        cyc();
        chk("ring_reload",      32'(pattern), 32'd1);
        chk("ring_reload_tick", 32'(tick),    32'd0);
        for (int n = 1; n <= 10; n++) begin
            repeat (8) cyc();
            chk("ring_seq",  32'(pattern), 32'(rtab[(n - 1) % 5]));
            chk("ring_wrap", 32'(wrap),    32'(n % 5 == 0));
        end

        // Bounce, div_sel=0, dir toggled randomly.
        mode = 2'b10; div_sel = 4'd0;
        cyc();
        chk("bounce_reload", 32'(pattern), 32'd1);
        for (int n = 1; n <= 16; n++) begin
            dir = 1'($urandom_range(0, 1));
            cyc(); cyc();
            chk("bounce_seq",  32'(pattern), 32'(btab[(n - 1) % 8]));
            chk("bounce_wrap", 32'(wrap),    32'(n % 8 == 0));
        end

        // Freeze mid-sequence for 20 cycles, then resume.
        repeat (6) cyc();
        chk("pre_freeze", 32'(pattern), 32'd8);
        enable = 1'b0;
        repeat (20) begin
            cyc();
            chk("frozen_pattern", 32'(pattern), 32'd8);
            chk("frozen_tick",    32'(tick),    32'd0);
        end
        enable = 1'b1;
        cyc(); cyc();
        chk("resume_pattern", 32'(pattern), 32'd16);
        repeat (4) cyc();

        // div_sel=15 clamps to DIV_BITS-1: period 8192.
        div_sel = 4'd15; mode = 2'b00;
        cyc();
        repeat (8191) cyc();
        chk("slow_no_tick", 32'(pattern), 32'd0);
        cyc();
        chk("slow_tick",    32'(tick),    32'd1);
        chk("slow_pattern", 32'(pattern), 32'd1);

        // Bounce until the flag is down, then async reset between edges.
        mode = 2'b10; div_sel = 4'd0;
        cyc();
        repeat (10) cyc();
        chk("bounce_down", 32'(pattern), 32'd8);
        #3 reset = 1'b0;
        #1;
        chk("async_pattern", 32'(pattern), 32'd0);
        chk("async_tick",    32'(tick),    32'd0);
        chk("async_wrap",    32'(wrap),    32'd0);
        m_reset();
        mode = 2'b00; div_sel = 4'd0; dir = 1'b0;
        #2 reset = 1'b1;
        repeat (20) cyc();
        chk("post_reset_john", 32'(pattern), 32'd0);
        chk("post_reset_wrap", 32'(wrap),    32'd1);

`ifdef JOHNSON_CHASER_EXT_STEP_EN
        // External steps with the prescaler effectively idle.
        div_sel = 4'd15; mode = 2'b01;
        cyc();
        mode = 2'b00;
        cyc();
        for (int p = 0; p < 3; p++) begin
            ext_step = 1'b1; cyc();
            ext_step = 1'b0; cyc();
            chk("ext_latency_hold", 32'(pattern), 32'(p == 0 ? 0 : etab[p - 1]));
            cyc();
            chk("ext_step", 32'(pattern), 32'(etab[p]));
            repeat (3) cyc();
        end
        ext_step = 1'b1;
        repeat (10) cyc();
        chk("ext_held", 32'(pattern), 32'(etab[3]));
        ext_step = 1'b0;
        repeat (4) cyc();
`endif

        // Randomized phase checked cycle by cycle against the model.
        repeat (250) begin
            mode    = 2'($urandom_range(0, 3));
            dir     = 1'($urandom_range(0, 1));
            div_sel = 4'($urandom_range(0, 3));
            enable  = ($urandom_range(0, 9) != 0);
`ifdef JOHNSON_CHASER_EXT_STEP_EN
            ext_step = 1'($urandom_range(0, 1));
`endif
            repeat ($urandom_range(1, 24)) cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/johnson_chaser_gen.md
Name: johnson_chaser_gen

Overview:
- Parametrised successor to the team's divide-by-2^N Johnson light-chaser.
- Replaces ripple-clocked divider flops with a fully synchronous prescaler and a clock-enable tick. Everything runs on a single clock.
- Pattern register supports Johnson, ring and bounce sequences, selectable direction and a runtime-selectable divide ratio.
- Sits behind the io_in/io_out wrapper of a user project; drives LEDs or segments.

Parameters:
- WIDTH, 5, pattern width in bits; legal range 2..8.
- DIV_BITS, 13, prescaler width in bits; legal range 1..16.

Ports:
- clk  input  1  single system clock; all flops on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- enable  input  1  1 = prescaler counts and pattern may step; 0 = everything frozen.
- mode  input  2  00 Johnson, 01 ring, 10 bounce, 11 hold.
- dir  input  1  0 = shift toward MSB, 1 = toward LSB; Johnson and ring only.
- div_sel  input  4  tick period = 2^(min(div_sel,DIV_BITS-1)+1) clk cycles.
- pattern  output  WIDTH  current pattern register.
- tick  output  1  one-cycle pulse on each step event.
- wrap  output  1  one-cycle pulse when the pattern returns to the mode start value.

Behaviour:
- Reset (reset=0, async):
  - prescaler = 0, pattern = 0, tick = 0, wrap = 0.
  - mode_q = 00, bounce direction flag = up.
- Prescaler:
  - Increments by 1 each cycle while enable=1, wrapping modulo 2^DIV_BITS.
  - Holds its value while enable=0.
  - k = min(div_sel, DIV_BITS-1).
  - Tick condition: enable=1 and prescaler[k:0] all ones.
  - tick output is the registered tick condition, so pattern and tick update on the same edge.
  - Changing div_sel mid-count takes effect immediately. No counter reset; the first period after a change may be shorter.
- Mode change:
  - mode is compared each cycle against the registered mode_q.
  - On a difference, the next edge sets:
    - mode_q = mode;
    - prescaler = 0;
    - pattern = start value of the new mode: Johnson 0, ring 1, bounce 1, hold unchanged;
    - bounce direction flag = up.
  - That edge produces no tick and no wrap. Mode change has priority over a coincident tick.
- Step rules (applied on tick, p = pattern):
  - Johnson, dir=0: {p[W-2:0], ~p[W-1]}.
  - Johnson, dir=1: {~p[0], p[W-1:1]}.
  - Ring, dir=0: rotate left. Ring, dir=1: rotate right.
  - Ring from an all-zero pattern: first step loads 1 instead of rotating.
  - Bounce (dir ignored):
    - One-hot bit moves up while the flag is up.
    - On reaching bit W-1, the flag flips to down on that same step. It flips back to up on reaching bit 0.
    - From a non-one-hot pattern, the step loads 1 and sets the flag up.
  - Hold: pattern is unchanged, but tick still pulses.
- Wrap:
  - Registered one-cycle pulse, coincident with the tick that produces the start value.
  - Only when the previous pattern differed from the start value; never in hold.
  - Periods: Johnson every 2*WIDTH ticks, ring every WIDTH ticks, bounce every 2*(WIDTH-1) ticks.
- Dir change mid-sequence: takes effect on the next tick with no reload. The Johnson code stays valid.
- enable=0 during a mode change: the reload still happens; the prescaler stays at 0.

Optional Feature:
- Macro: JOHNSON_CHASER_EXT_STEP_EN.
- With the macro defined:
  - Adds input ext_step (1 bit, asynchronous source).
  - ext_step passes through a 2-flop synchroniser (reset to 0) and a rising-edge detector.
  - A detected edge while enable=1 forces a tick in that cycle, ORed with the prescaler tick. Simultaneous edges give one step.
  - Latency from the ext_step rising edge to the pattern change: 3 clk edges.
- Without the macro: the port does not exist and ticks come only from the prescaler.

Test Plan:
- Reset, WIDTH=5, mode=00, dir=0, div_sel=0, enable=1 -> a step every 2 cycles; pattern sequence 00000,00001,00011,00111,01111,11111,11110,11100,11000,10000,00000; wrap exactly on the 10th tick.
- mode=01, dir=1, div_sel=2 -> reload to 00001; ticks every 8 cycles; pattern sequence 10000,01000,...; wrap every 5 ticks; no tick on the reload edge.
- mode=10, div_sel=0 -> 00001 up to 10000 then back down to 00001; wrap every 8 ticks; dir toggling has no effect.
- enable=0 for 20 cycles mid-sequence -> pattern, prescaler, tick and wrap all frozen; resumes the exact sequence afterwards. Then div_sel=15 with DIV_BITS=13 -> period 8192.
- Assert reset mid-bounce while the flag is down -> outputs 0 asynchronously, before the next edge. After release, mode_q=00 and the Johnson sequence runs from 00000.
- JOHNSON_CHASER_EXT_STEP_EN, div_sel=15, mode=00: pulse ext_step 3 times -> pattern 00111, each change 3 edges after its pulse; ext_step held high gives only one step.
